machine_timer: RTL and testbench
================================

# machine_timer

Memory-mapped RISC-V machine timer (mtime/mtimecmp) that originates the `timer_timeout` interrupt request consumed by the core controller FSM. It holds a free-running 64-bit `mtime` counter and a 64-bit `mtimecmp` compare value, both accessible over a simple 32-bit request/response register port. It asserts a level interrupt while `mtime >= mtimecmp` and the comparator is armed. The interrupt stays asserted until software moves `mtimecmp` forward in the handler.

## Interface
- `BASE_ADDR`, `32'h0200_0000`: register window base; `req_addr[31:5]` must match it.
- `CMP_RESET`, `64'hFFFF_FFFF_FFFF_FFFF`: reset value of `mtimecmp`.
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: register access request; accepted every cycle (no backpressure).
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input 32: byte address; `[4:2]` selects the register; `[1:0]` is ignored.
- `req_wdata` input 32: write data.
- `rsp_valid` output 1: one-cycle pulse, one per accepted request (reads and writes).
- `rsp_rdata` output 32: read data, valid with `rsp_valid`; 0 for writes and unmapped addresses.
- `timer_timeout` output 1: registered level interrupt request to the core controller.

## Operation
- Register map (offset `[4:2]`):
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 CTRL
  - 5 STATUS (RO)
  - 6–7 unmapped: writes ignored, reads return 0.
- CTRL bits:
  - bit0 `enable`: counting on/off.
  - bits[15:8] `prescale`: RW only with the configuration macro; otherwise reads 0.
  - Other bits: read 0.
- STATUS bits:
  - bit0 `timer_timeout`.
  - bit1 `armed`.
- Counting: with `enable=1`, `mtime` increments by 1 on each tick, as a 64-bit unsigned count with carry from LO into HI.
- Wrap-around: `FFFF_FFFF_FFFF_FFFF` increments to 0.
- Compare: `hit = armed && (mtime >= mtimecmp)`, 64-bit unsigned.
- Arm state machine (states DISARMED and ARMED):
  - Reset → DISARMED.
  - Write MTIMECMP_LO → DISARMED.
  - Write MTIMECMP_HI → ARMED.
  - Software writes LO first, then HI, so no spurious interrupt is raised from a half-updated compare value.
  - Writing MTIME_LO or MTIME_HI does not change the arm state.
- Coherent 64-bit read:
  - A read of MTIME_LO captures the `mtime[63:32]` value of that same cycle into a shadow register.
  - A subsequent MTIME_HI read returns the shadow.
  - The shadow is cleared to the live value on reset. Without a prior LO read it holds the value from the last LO read.
- Writes take effect at the clock edge of the accepting cycle.

## Timing
- Reset values:
  - `mtime=0`, shadow `=0`, `mtimecmp=CMP_RESET`
  - `enable=0`, `prescale=0`, DISARMED
  - `timer_timeout=0`, `rsp_valid=0`, `rsp_rdata=0`
- Response latency: `rsp_valid` is asserted exactly 1 cycle after `req_valid`. Back-to-back requests produce back-to-back responses.
- Read data reflects register state before any same-cycle write or tick.
- `timer_timeout` is registered from `hit`, so it follows `hit` with 1-cycle latency. It deasserts the cycle after an MTIMECMP_LO write, or after an HI write that makes `mtime < mtimecmp`.
- Simultaneous MTIME write and tick: the write wins and that half gets no increment that cycle. A carry from LO into HI is suppressed only if HI itself is written.
- Clearing `enable` freezes `mtime` the next cycle. Clearing it does not clear `timer_timeout`.
- Assertion of `reset_n` mid-operation forces all reset values immediately, including dropping any in-flight `rsp_valid`.

## Configuration
- `MACHINE_TIMER_PRESCALER_EN` defined:
  - An 8-bit prescale counter runs while `enable=1`.
  - A tick occurs when the counter equals `prescale`; the counter then resets to 0.
  - The result is one increment every `prescale+1` cycles.
  - Writing CTRL clears the prescale counter.
- Not defined: a tick occurs every cycle while `enable=1`; CTRL[15:8] is read-only zero.

## Test plan
- Reset, then read all 8 offsets → MTIME 0/0, MTIMECMP `FFFFFFFF`/`FFFFFFFF`, CTRL 0, STATUS 0, offsets 6–7 read 0; each response arrives 1 cycle after its request.
- Enable=1; write CMP_LO=20, then CMP_HI=0 at mtime≈5 → `timer_timeout` rises 1 cycle after mtime reaches 20; a CMP_LO write drops it the next cycle, and it stays low until CMP_HI is rewritten.
- Write MTIME_LO=`FFFF_FFFE`, MTIME_HI=0, enable → after 3 ticks MTIME_LO reads 1 and MTIME_HI reads 1; a LO read at the carry cycle then an HI read is coherent.
- Write MTIME=`FFFF_FFFF_FFFF_FFFF`, enable → the next tick gives 0 with no stuck carry; with CMP=0 armed, `timer_timeout` stays high.
- Same-cycle MTIME_LO write of 100 and a tick → the next read returns 100, not 101.
- With `MACHINE_TIMER_PRESCALER_EN`, prescale=3 → mtime advances 1 per 4 cycles; 40 cycles give mtime=10. `reset_n` pulsed low mid-count → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp behind a 32-bit request/response port,
// raising a level timer_timeout. Optional prescaler enabled by MACHINE_TIMER_PRESCALER_EN.
module machine_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        timer_timeout
);

  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_CTRL        = 3'd4,
    REG_STATUS      = 3'd5,
    REG_UNMAPPED_6  = 3'd6,
    REG_UNMAPPED_7  = 3'd7
  } reg_sel_e;

  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } arm_state_e;

  reg_sel_e   reg_sel;
  arm_state_e arm_state, arm_next;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] mtime_hi_shadow;
  logic        enable;
  logic        tick;
  logic        lo_carry;
  logic        hit;
  logic        addr_hit;
  logic        wr_en;
  logic        rd_en;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_ctrl;
  logic        rd_mtime_lo;
  logic [31:0] rdata_next;
  logic        unused_addr_bits;

  // Byte-lane bits carry no meaning on this word-only port.
  assign unused_addr_bits = ^req_addr[1:0];

  // ---------------------------------------------------------------------------
  // Request decode: every request gets a response; only in-window ones act.
  // ---------------------------------------------------------------------------
  assign reg_sel     = reg_sel_e'(req_addr[4:2]);
  assign addr_hit    = (req_addr[31:5] == BASE_ADDR[31:5]);
  assign wr_en       = req_valid && addr_hit && req_write;
  assign rd_en       = req_valid && addr_hit && !req_write;
  assign wr_mtime_lo = wr_en && (reg_sel == REG_MTIME_LO);
  assign wr_mtime_hi = wr_en && (reg_sel == REG_MTIME_HI);
  assign wr_cmp_lo   = wr_en && (reg_sel == REG_MTIMECMP_LO);
  assign wr_cmp_hi   = wr_en && (reg_sel == REG_MTIMECMP_HI);
  assign wr_ctrl     = wr_en && (reg_sel == REG_CTRL);
  assign rd_mtime_lo = rd_en && (reg_sel == REG_MTIME_LO);

  // ---------------------------------------------------------------------------
  // Control register and tick generation
  // ---------------------------------------------------------------------------
`ifdef MACHINE_TIMER_PRESCALER_EN
  logic [7:0] prescale;
  logic [7:0] psc_cnt;

  assign tick = enable && (psc_cnt == prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b0;
      prescale <= 8'd0;
    end else if (wr_ctrl) begin
      enable   <= req_wdata[0];
      prescale <= req_wdata[15:8];
    end
  end

  // A CTRL write restarts the divider so a new ratio takes effect cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_cnt <= 8'd0;
    end else if (wr_ctrl) begin
      psc_cnt <= 8'd0;
    end else if (enable) begin
      psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
    end
  end
`else
  assign tick = enable;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable <= 1'b0;
    end else if (wr_ctrl) begin
      enable <= req_wdata[0];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // mtime: a software write to a half overrides that half's increment only.
  // ---------------------------------------------------------------------------
  assign lo_carry = tick && (&mtime[31:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime <= 64'd0;
    end else begin
      if (wr_mtime_lo) begin
        mtime[31:0] <= req_wdata;
      end else if (tick) begin
        mtime[31:0] <= mtime[31:0] + 32'd1;
      end
      if (wr_mtime_hi) begin
        mtime[63:32] <= req_wdata;
      end else if (lo_carry) begin
        mtime[63:32] <= mtime[63:32] + 32'd1;
      end
    end
  end

  // Snapshot of the upper half taken with each LO read for coherent 64-bit reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime_hi_shadow <= 32'd0;
    end else if (rd_mtime_lo) begin
      mtime_hi_shadow <= mtime[63:32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtimecmp <= CMP_RESET;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= req_wdata;
      if (wr_cmp_hi) mtimecmp[63:32] <= req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Arm FSM: LO write disarms, HI write arms, so a half-updated compare
  // value can never raise the interrupt.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) arm_state <= DISARMED;
    else          arm_state <= arm_next;
  end

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    arm_next = arm_state;
    if (wr_cmp_lo)      arm_next = DISARMED;
    else if (wr_cmp_hi) arm_next = ARMED;
  end

  assign hit = (arm_state == ARMED) && (mtime >= mtimecmp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timer_timeout <= 1'b0;
    else          timer_timeout <= hit;
  end

  // ---------------------------------------------------------------------------
  // Read path: data reflects pre-edge state; writes and unmapped return 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_next = 32'd0;
    if (rd_en) begin
      unique case (reg_sel)
        REG_MTIME_LO:    rdata_next = mtime[31:0];
        REG_MTIME_HI:    rdata_next = mtime_hi_shadow;
        REG_MTIMECMP_LO: rdata_next = mtimecmp[31:0];
        REG_MTIMECMP_HI: rdata_next = mtimecmp[63:32];
`ifdef MACHINE_TIMER_PRESCALER_EN
        REG_CTRL:        rdata_next = {16'd0, prescale, 7'd0, enable};
`else
        REG_CTRL:        rdata_next = {31'd0, enable};
`endif
        REG_STATUS:      rdata_next = {30'd0, (arm_state == ARMED), timer_timeout};
        REG_UNMAPPED_6,
        REG_UNMAPPED_7:  rdata_next = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      rsp_valid <= req_valid;
      rsp_rdata <= rdata_next;
    end
  end

endmodule

// File: tb/tb_machine_timer.sv
// Directed self-checking bench for machine_timer; covers prescaler when
// MACHINE_TIMER_PRESCALER_EN is defined.
module tb_machine_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [2:0]  MTIME_LO = 3'd0, MTIME_HI = 3'd1, CMP_LO = 3'd2,
                          CMP_HI = 3'd3, CTRL = 3'd4, STATUS = 3'd5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        timer_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  machine_timer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .timer_timeout(timer_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the request is accepted at the next posedge and the
  // response is checked at the following negedge, so calls chain back-to-back.
  task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check(tag, rsp_rdata, wr ? 32'd0 : exp);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    access("write", 1'b1, {BASE[31:5], off, 2'b00}, data, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
    access(tag, 1'b0, {BASE[31:5], off, 2'b00}, 32'd0, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    #12;
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset timeout", {31'd0, timer_timeout}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check("idle rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset values of the whole window, back-to-back.
    rd("rst mtime_lo", 3'd0, 32'd0);
    rd("rst mtime_hi", 3'd1, 32'd0);
    rd("rst cmp_lo",   3'd2, 32'hFFFF_FFFF);
    rd("rst cmp_hi",   3'd3, 32'hFFFF_FFFF);
    rd("rst ctrl",     3'd4, 32'd0);
    rd("rst status",   3'd5, 32'd0);
    rd("rst off6",     3'd6, 32'd0);
    rd("rst off7",     3'd7, 32'd0);
    idle(1);
    check("rsp_valid drops", {31'd0, rsp_valid}, 32'd0);

    // Unmapped offset, foreign base, CTRL reserved bits.
    wr(3'd6, 32'hDEAD_BEEF);
    rd("off6 after write", 3'd6, 32'd0);
    access("foreign write", 1'b1, 32'h0300_0000, 32'h1234, 32'd0);
    access("foreign read", 1'b0, 32'h0300_0008, 32'd0, 32'd0);
    rd("mtime_lo untouched", MTIME_LO, 32'd0);
    wr(CTRL, 32'hFFFF_FFFE);
`ifdef MACHINE_TIMER_PRESCALER_EN
    rd("ctrl rsvd", CTRL, 32'h0000_FF00);
`else
    rd("ctrl rsvd", CTRL, 32'd0);
`endif
    wr(CTRL, 32'd0);

    // Compare and arm: mtime after edge Ek is k-1, timeout rises at E22.
    wr(CTRL, 32'd1);
    wr(CMP_LO, 32'd20);
    wr(CMP_HI, 32'd0);
    idle(18);
    check("timeout before 20", {31'd0, timer_timeout}, 32'd0);
    idle(1);
    check("timeout at 20", {31'd0, timer_timeout}, 32'd1);
    rd("mtime at E23", MTIME_LO, 32'd21);
    rd("status armed+hit", STATUS, 32'd3);
    wr(CMP_LO, 32'd20);
    check("timeout lag", {31'd0, timer_timeout}, 32'd1);
    idle(1);
    check("timeout drop", {31'd0, timer_timeout}, 32'd0);
    idle(3);
    check("timeout stays low", {31'd0, timer_timeout}, 32'd0);
    rd("status disarmed", STATUS, 32'd0);
    wr(CMP_HI, 32'd0);
    check("rearm lag", {31'd0, timer_timeout}, 32'd0);
    idle(1);
    check("rearm rise", {31'd0, timer_timeout}, 32'd1);

    // Carry from LO into HI, then freeze by clearing enable.
    wr(CTRL, 32'd0);
    wr(MTIME_LO, 32'hFFFF_FFFE);
    wr(MTIME_HI, 32'd0);
    wr(CTRL, 32'd1);
    idle(2);
    wr(CTRL, 32'd0);
    rd("carry lo", MTIME_LO, 32'd1);
    rd("carry hi", MTIME_HI, 32'd1);
    check("timeout kept on disable", {31'd0, timer_timeout}, 32'd1);

    // Coherent read across the carry cycle.
    wr(MTIME_LO, 32'hFFFF_FFFE);
    wr(MTIME_HI, 32'd0);
    wr(CTRL, 32'd1);
    idle(1);
    rd("coherent lo", MTIME_LO, 32'hFFFF_FFFF);
    rd("coherent hi", MTIME_HI, 32'd0);
    wr(CTRL, 32'd0);
    rd("shadow held", MTIME_HI, 32'd0);
    rd("frozen lo", MTIME_LO, 32'd2);
    rd("frozen hi", MTIME_HI, 32'd1);

    // Full 64-bit wrap with compare at zero.
    wr(CMP_LO, 32'd0);
    wr(CMP_HI, 32'd0);
    wr(MTIME_LO, 32'hFFFF_FFFF);
    wr(MTIME_HI, 32'hFFFF_FFFF);
    wr(CTRL, 32'd1);
    wr(CTRL, 32'd0);
    check("timeout at wrap", {31'd0, timer_timeout}, 32'd1);
    rd("wrap lo", MTIME_LO, 32'd0);
    rd("wrap hi", MTIME_HI, 32'd0);
    check("timeout after wrap", {31'd0, timer_timeout}, 32'd1);

    // Write beats tick on the written half.
    wr(CTRL, 32'd1);
    wr(MTIME_LO, 32'd100);
    rd("write wins", MTIME_LO, 32'd100);
    wr(CTRL, 32'd0);
    // LO write with carry: HI still increments.
    wr(MTIME_LO, 32'hFFFF_FFFF);
    wr(MTIME_HI, 32'd5);
    wr(CTRL, 32'd1);
    wr(MTIME_LO, 32'd100);
    rd("lo write lo", MTIME_LO, 32'd100);
    rd("lo write carry hi", MTIME_HI, 32'd6);
    wr(CTRL, 32'd0);
    // HI write with carry: carry suppressed.
    wr(MTIME_LO, 32'hFFFF_FFFF);
    wr(MTIME_HI, 32'd5);
    wr(CTRL, 32'd1);
    wr(MTIME_HI, 32'd9);
    wr(CTRL, 32'd0);
    rd("hi write lo", MTIME_LO, 32'd1);
    rd("hi write hi", MTIME_HI, 32'd9);

    // Tick rate over 40 cycles.
    wr(MTIME_LO, 32'd0);
    wr(MTIME_HI, 32'd0);
`ifdef MACHINE_TIMER_PRESCALER_EN
    wr(CTRL, 32'h0000_0301);
    idle(39);
    wr(CTRL, 32'd0);
    rd("prescale 40 cycles", MTIME_LO, 32'd10);
`else
    wr(CTRL, 32'd1);
    idle(39);
    wr(CTRL, 32'd0);
    rd("count 40 cycles", MTIME_LO, 32'd40);
`endif

    // Asynchronous reset while a response is in flight.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = {BASE[31:5], STATUS, 2'b00};
    @(posedge clk);
    #2;
    check("pre-reset rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("pre-reset status", rsp_rdata, 32'd3);
    reset_n = 1'b0;
    #1;
    check("async rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("async rsp_rdata", rsp_rdata, 32'd0);
    check("async timeout", {31'd0, timer_timeout}, 32'd0);
    req_valid = 1'b0;
    req_addr  = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    rd("post-reset cmp_lo", CMP_LO, 32'hFFFF_FFFF);
    rd("post-reset status", STATUS, 32'd0);
    rd("post-reset mtime_lo", MTIME_LO, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
